// File: rtl/reg_serializer.sv
// reg_serializer: parallel-in, serial-out reader for the register datapath.
// A word is captured through a valid/ready handshake, shifted out one bit per
// accepted serial beat, and a one-cycle done pulse marks its complete exit.
module reg_serializer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Bit-order dependent views of the capture word and the shift register.
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // Select which end of the word feeds the serial output.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit     = d[WIDTH-1];
      next_bit      = shreg_q[WIDTH-2];
      shreg_shifted = shreg_q << 1;
    end else begin
      first_bit     = d[0];
      next_bit      = shreg_q[1];
      shreg_shifted = shreg_q >> 1;
    end
  end

  // Next-state and next-output logic for the IDLE/SHIFT controller.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d      = SHIFT;
          shreg_d      = d;
          cnt_d        = '0;
          sout_d       = first_bit;
          sout_valid_d = 1'b1;
          busy_d       = 1'b1;
        end
      end

      SHIFT: begin
        // Without a beat everything holds, so no bit is dropped or repeated.
        if (sout_ready) begin
          if (cnt_q == LAST_IDX) begin
            state_d      = IDLE;
            shreg_d      = '0;
            cnt_d        = '0;
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end else begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + CW'(1);
            sout_d  = next_bit;
          end
        end
      end

      default: begin
        state_d      = IDLE;
        shreg_d      = '0;
        cnt_d        = '0;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // in_ready is the only combinational output: capture is allowed in IDLE.
  assign in_ready   = (state_q == IDLE);
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
